// File: rtl/voq_buffer.sv
// voq_buffer: per-input virtual output queue buffer feeding the iSLIP scheduler.
// One circular queue per output port lives in a shared memory. Each non-empty
// queue raises one bit of this input's request row. A valid grant pops the head
// of the granted queue, and the cell appears on out_* one cycle later.
module voq_buffer #(
  parameter int number_ports = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int DEST_WIDTH   = (number_ports > 1) ? $clog2(number_ports) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [DEST_WIDTH-1:0]              in_dest,
  output logic [number_ports-1:0]            request,
  input  logic                               grant_valid,
  input  logic [DEST_WIDTH-1:0]              grant_dest,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [DEST_WIDTH-1:0]              out_dest,
  output logic                               grant_error,
  output logic [ADDR_WIDTH+number_ports:0]   occupancy
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int OCC_W   = ADDR_WIDTH + number_ports + 1;
  localparam int MEM_AW  = DEST_WIDTH + ADDR_WIDTH;
  localparam int MEM_N   = number_ports * DEPTH;
  localparam int IDX_N   = 1 << DEST_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Marks which destination encodings name an existing output port.
  function automatic logic [IDX_N-1:0] dest_mask_f();
    logic [IDX_N-1:0] m;
    m = '0;
    for (int i = 0; i < IDX_N; i++) begin
      m[i] = (i < number_ports);
    end
    return m;
  endfunction

  localparam logic [IDX_N-1:0] DEST_MASK = dest_mask_f();

  logic [ADDR_WIDTH-1:0] head_q  [number_ports];
  logic [ADDR_WIDTH-1:0] head_d  [number_ports];
  logic [ADDR_WIDTH-1:0] tail_q  [number_ports];
  logic [ADDR_WIDTH-1:0] tail_d  [number_ports];
  logic [CNT_W-1:0]      count_q [number_ports];
  logic [CNT_W-1:0]      count_d [number_ports];
  logic [DATA_WIDTH-1:0] mem_q   [MEM_N];
  logic [DATA_WIDTH-1:0] mem_d   [MEM_N];

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
  logic                  grant_error_q, grant_error_d;
  logic [OCC_W-1:0]      occupancy_q, occupancy_d;

  logic                  in_dest_ok_s, grant_dest_ok_s;
  logic [DEST_WIDTH-1:0] in_idx_s, grant_idx_s;
  logic                  enq_s, deq_s;
  logic [MEM_AW-1:0]     wr_addr_s, rd_addr_s;

  // Destination decode, in_ready and the enqueue/dequeue fire conditions.
  always_comb begin
    in_dest_ok_s    = DEST_MASK[in_dest];
    grant_dest_ok_s = DEST_MASK[grant_dest];
    in_idx_s        = in_dest_ok_s ? in_dest : '0;
    grant_idx_s     = grant_dest_ok_s ? grant_dest : '0;
    in_ready        = in_dest_ok_s && (count_q[in_idx_s] != FULL_CNT);
    enq_s           = in_valid && in_ready;
    deq_s           = grant_valid && grant_dest_ok_s && (count_q[grant_idx_s] != '0);
    wr_addr_s       = {in_idx_s, tail_q[in_idx_s]};
    rd_addr_s       = {grant_idx_s, head_q[grant_idx_s]};
  end

  // Request row: one bit per non-empty queue, taken from registered counts only.
  always_comb begin
    request = '0;
    for (int k = 0; k < number_ports; k++) begin
      request[k] = (count_q[k] != '0);
    end
  end

  // Next-state for pointers, counts, occupancy and the registered output cell.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    occupancy_d   = occupancy_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    out_dest_d    = out_dest_q;
    grant_error_d = grant_valid && !deq_s;

    if (enq_s) begin
      tail_d[in_idx_s] = tail_q[in_idx_s] + ADDR_WIDTH'(1);
    end else begin
      tail_d[in_idx_s] = tail_q[in_idx_s];
    end

    if (deq_s) begin
      head_d[grant_idx_s] = head_q[grant_idx_s] + ADDR_WIDTH'(1);
      out_valid_d         = 1'b1;
      out_data_d          = mem_q[rd_addr_s];
      out_dest_d          = grant_idx_s;
    end else begin
      head_d[grant_idx_s] = head_q[grant_idx_s];
    end

    // Same-queue push and pop cancel; otherwise apply each independently.
    for (int k = 0; k < number_ports; k++) begin
      if (enq_s && (in_idx_s == DEST_WIDTH'(k)) && !(deq_s && (grant_idx_s == DEST_WIDTH'(k)))) begin
        count_d[k] = count_q[k] + CNT_W'(1);
      end else if (deq_s && (grant_idx_s == DEST_WIDTH'(k)) && !(enq_s && (in_idx_s == DEST_WIDTH'(k)))) begin
        count_d[k] = count_q[k] - CNT_W'(1);
      end else begin
        count_d[k] = count_q[k];
      end
    end

    if (enq_s && !deq_s) begin
      occupancy_d = occupancy_q + OCC_W'(1);
    end else if (deq_s && !enq_s) begin
      occupancy_d = occupancy_q - OCC_W'(1);
    end else begin
      occupancy_d = occupancy_q;
    end
  end

  // Memory write port: the incoming cell lands at its queue's tail slot.
  always_comb begin
    mem_d = mem_q;
    if (enq_s) begin
      mem_d[wr_addr_s] = in_data;
    end else begin
      mem_d[wr_addr_s] = mem_q[wr_addr_s];
    end
  end

  // Cell storage; contents need no reset because pointers and counts gate every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state and output registers with synchronous reset taking precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < number_ports; k++) begin
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
        count_q[k] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_dest_q    <= '0;
      grant_error_q <= 1'b0;
      occupancy_q   <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_dest_q    <= out_dest_d;
      grant_error_q <= grant_error_d;
      occupancy_q   <= occupancy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_dest    = out_dest_q;
  assign grant_error = grant_error_q;
  assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_voq_buffer.sv
// Self-checking bench for voq_buffer: directed scenarios followed by random
// traffic, compared against a queue-based reference model of the VOQ rules.
module tb_voq_buffer;

  localparam int NP = 4;
  localparam int D  = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [3:0] request;
  logic       grant_valid;
  logic [1:0] grant_dest;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_dest;
  logic       grant_error;
  logic [6:0] occupancy;

  voq_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dest     (in_dest),
    .request     (request),
    .grant_valid (grant_valid),
    .grant_dest  (grant_dest),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_dest    (out_dest),
    .grant_error (grant_error),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: one FIFO per output plus the expected output registers.
  logic [7:0] mq [NP][$];
  logic       exp_ov;
  logic [7:0] exp_od;
  logic [1:0] exp_odst;
  logic       exp_ge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_request();
    logic [3:0] r;
    for (int k = 0; k < NP; k++) r[k] = (mq[k].size() != 0);
    return r;
  endfunction

  function automatic int exp_occ();
    int s;
    s = 0;
    for (int k = 0; k < NP; k++) s += mq[k].size();
    return s;
  endfunction

  // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input logic [1:0] dst,
                      input bit gv, input logic [1:0] gd);
    bit exp_ready;
    bit deq;
    @(negedge clk);
    reset       = rst;
    in_valid    = v;
    in_data     = d;
    in_dest     = dst;
    grant_valid = gv;
    grant_dest  = gd;
    #1;
    exp_ready = (int'(dst) < NP) && (mq[dst].size() != D);
    if (!rst) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (rst) begin
      for (int k = 0; k < NP; k++) mq[k].delete();
      exp_ov   = 1'b0;
      exp_od   = 8'h00;
      exp_odst = 2'd0;
      exp_ge   = 1'b0;
    end else begin
      deq    = gv && (int'(gd) < NP) && (mq[gd].size() != 0);
      exp_ge = gv && !deq;
      exp_ov = deq;
      if (deq) begin
        exp_od   = mq[gd].pop_front();
        exp_odst = gd;
      end
      if (v && exp_ready) mq[dst].push_back(d);
    end
    @(posedge clk);
    #1;
    chk("request",     {28'd0, request},     {28'd0, exp_request()});
    chk("occupancy",   {25'd0, occupancy},   32'(exp_occ()));
    chk("out_valid",   {31'd0, out_valid},   {31'd0, exp_ov});
    chk("out_data",    {24'd0, out_data},    {24'd0, exp_od});
    chk("out_dest",    {30'd0, out_dest},    {30'd0, exp_odst});
    chk("grant_error", {31'd0, grant_error}, {31'd0, exp_ge});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0;
    grant_valid = 1'b0; grant_dest = 2'd0;
    exp_ov = 1'b0; exp_od = 8'h00; exp_odst = 2'd0; exp_ge = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);

    // Three cells to dest 2; request bit 2 rises the cycle after the first write.
    step(1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 2'd0);
    chk("s1_req_after_first", {28'd0, request}, 32'h4);
    step(1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 2'd0);
    step(1'b0, 1'b1, 8'h33, 2'd2, 1'b0, 2'd0);
    chk("s1_occ", {25'd0, occupancy}, 32'd3);

    // Fill dest 1, then a fifth offer is refused; dest 0 stays ready.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i), 2'd1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 8'h99, 2'd1, 1'b0, 2'd0);
    chk("s2_full_ready", {31'd0, in_ready}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);

    // Drain dest 2 with three back-to-back grants.
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd2);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd2);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd2);
    chk("s3_last_data", {24'd0, out_data}, 32'h33);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);

    // Grant to empty queue 3.
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd3);
    chk("s4_grant_error", {31'd0, grant_error}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);

    // Empty-queue grant with simultaneous enqueue: error, enqueue proceeds.
    step(1'b0, 1'b1, 8'h01, 2'd0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 8'h02, 2'd0, 1'b0, 2'd0);

    // Simultaneous push/pop on queue 0, repeated to wrap the pointers.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h50 + 8'(i), 2'd0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd0);
    chk("s5_last_popped", {24'd0, out_data}, 32'h59);

    // Reset while out_valid is high, several queues occupied and a cell offered.
    step(1'b0, 1'b1, 8'h61, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 8'h62, 2'd2, 1'b0, 2'd0);
    step(1'b0, 1'b1, 8'h63, 2'd3, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd1);
    chk("s6_ov_before_reset", {31'd0, out_valid}, 32'd1);
    step(1'b1, 1'b1, 8'h77, 2'd2, 1'b1, 2'd0);
    chk("s6_req_after_reset", {28'd0, request}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 2'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6),
           8'($urandom),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 5),
           2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
